// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared RC4 definitions for the key-scheduling and PRGA
//                blocks: PRGA state encoding, message-length and drop-phase
//                constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

    // Longest message: ct[0] holds the length in one byte.
    localparam int unsigned MSG_LEN_MAX = 255;

    // Keystream bytes discarded by the optional drop phase.
    localparam int unsigned DROP_N      = 256;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        LEN  = 4'd1,
        WLEN = 4'd2,
        RDI  = 4'd3,
        RDJ  = 4'd4,
        WRI  = 4'd5,
        WRJ  = 4'd6,
        RDP  = 4'd7,
        WRP  = 4'd8
    } prga_state_t;

endpackage
`default_nettype wire

// File: rtl/prga.sv
`default_nettype none
// ============================================================================
//  Module      : prga
//  Description : RC4 pseudo-random generation and decryption. Walks an
//                already-permuted 256x8 S RAM, XORs the keystream with the
//                ciphertext RAM and writes the plaintext RAM. ct[0]/pt[0]
//                carry the message length L; bytes 1..L are data.
//  Options     : PRGA_DROP256_EN - when defined, 256 swap-only iterations
//                run before the first keystream byte (RC4-drop256).
//  Ports       : clk, rst_n (sync, active-low)
//                en / rdy         - start request / idle handshake
//                s_*              - S RAM read/write port (1-cycle reads)
//                ct_addr/ct_rddata- ciphertext RAM read port
//                pt_*             - plaintext RAM write port
//  Revision    : 1.0 - initial release
// ============================================================================
module prga
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    localparam int unsigned CNT_W = $clog2(MSG_LEN_MAX + 1);

    prga_state_t      r_state;
    prga_state_t      w_state_nxt;

    logic [7:0]       r_i;
    logic [7:0]       r_j;
    logic [7:0]       r_si;
    logic [7:0]       r_sj;
    logic [CNT_W-1:0] r_k;
    logic [CNT_W-1:0] r_ml;

    logic [7:0]       w_i_inc;
    logic [7:0]       w_j_sum;
    logic [7:0]       w_t_idx;
    logic             w_s_wren;
    logic             w_pt_wren;

`ifdef PRGA_DROP256_EN
    localparam int unsigned DROP_W = $clog2(DROP_N) + 1;
    logic [DROP_W-1:0] r_drop;
`endif

    // All index arithmetic wraps modulo 256 through the 8-bit result width.
    assign w_i_inc = r_i + 8'd1;
    assign w_j_sum = r_j + s_rddata;
    assign w_t_idx = r_si + r_sj;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_si    <= '0;
            r_sj    <= '0;
            r_k     <= '0;
            r_ml    <= '0;
`ifdef PRGA_DROP256_EN
            r_drop  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_i <= '0;
                        r_j <= '0;
                    end
                end
                WLEN: begin
                    r_ml <= ct_rddata;
                    r_k  <= CNT_W'(1);
`ifdef PRGA_DROP256_EN
                    r_drop <= DROP_W'(DROP_N);
`endif
                end
                RDI: r_i <= w_i_inc;
                RDJ: begin
                    r_si <= s_rddata;
                    r_j  <= w_j_sum;
                end
                WRI: r_sj <= s_rddata;
`ifdef PRGA_DROP256_EN
                WRJ: begin
                    if (r_drop != '0) begin
                        r_drop <= r_drop - DROP_W'(1);
                    end
                end
`endif
                WRP: begin
                    if (r_k != r_ml) begin
                        r_k <= r_k + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        rdy         = 1'b0;
        s_addr      = '0;
        s_wrdata    = '0;
        w_s_wren    = 1'b0;
        ct_addr     = '0;
        pt_addr     = '0;
        pt_wrdata   = '0;
        w_pt_wren   = 1'b0;

        case (r_state)
            IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    w_state_nxt = LEN;
                end
            end
            LEN: begin
                ct_addr     = 8'd0;
                w_state_nxt = WLEN;
            end
            WLEN: begin
                // Length byte is copied straight through to pt[0].
                pt_addr     = 8'd0;
                pt_wrdata   = ct_rddata;
                w_pt_wren   = 1'b1;
                w_state_nxt = (ct_rddata == 8'd0) ? IDLE : RDI;
            end
            RDI: begin
                s_addr      = w_i_inc;
                w_state_nxt = RDJ;
            end
            RDJ: begin
                s_addr      = w_j_sum;
                w_state_nxt = WRI;
            end
            WRI: begin
                // s_rddata is S[j]; it lands in S[i].
                s_addr      = r_i;
                s_wrdata    = s_rddata;
                w_s_wren    = 1'b1;
                w_state_nxt = WRJ;
            end
            WRJ: begin
                s_addr      = r_j;
                s_wrdata    = r_si;
                w_s_wren    = 1'b1;
`ifdef PRGA_DROP256_EN
                w_state_nxt = (r_drop != '0) ? RDI : RDP;
`else
                w_state_nxt = RDP;
`endif
            end
            RDP: begin
                s_addr      = w_t_idx;
                ct_addr     = r_k;
                w_state_nxt = WRP;
            end
            WRP: begin
                pt_addr     = r_k;
                pt_wrdata   = s_rddata ^ ct_rddata;
                w_pt_wren   = 1'b1;
                w_state_nxt = (r_k == r_ml) ? IDLE : RDI;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A reset arriving mid-message must not let the in-flight write land
    // on the same edge that abandons the run.
    assign s_wren  = w_s_wren & rst_n;
    assign pt_wren = w_pt_wren & rst_n;

endmodule
`default_nettype wire

// File: tb/tb_prga.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prga
//  Description : Self-checking bench for prga. Behavioural RAMs with 1-cycle
//                reads, a software RC4 reference feeding a queue of expected
//                plaintext writes, and directed steps for the length, reset,
//                en-handshake and drop-phase corner cases.
//  Options     : PRGA_DROP256_EN - must match the RTL build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prga;

`ifdef PRGA_DROP256_EN
    localparam int DROP = 256;
`else
    localparam int DROP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr, ct_rddata;
    logic [7:0] pt_addr, pt_wrdata;
    logic       pt_wren;

    always #5 clk = ~clk;

    prga dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
    );

    // ------------------------------------------------------------------------
    // RAM models
    // ------------------------------------------------------------------------
    logic [7:0] s_mem  [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] s_rd_q, ct_rd_q;
    logic       load_ident = 1'b0;

    always @(posedge clk) begin
        if (load_ident) begin
            for (int a = 0; a < 256; a++) s_mem[a] <= 8'(a);
        end else if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
        end
        s_rd_q  <= s_mem[s_addr];
        ct_rd_q <= ct_mem[ct_addr];
        if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    end
    assign s_rddata  = s_rd_q;
    assign ct_rddata = ct_rd_q;

    // ------------------------------------------------------------------------
    // Checking and scoreboard
    // ------------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    int n_pt_wr = 0;
    int n_s_wr = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_q [$];
    logic [7:0] exp_pt [256];
    logic [7:0] m_s    [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (s_wren || pt_wren) begin
            check("one_wren", {30'd0, s_wren, pt_wren} & 32'h3, s_wren ? 32'h2 : 32'h1);
        end
        if (s_wren) n_s_wr++;
        if (pt_wren) begin
            wr_t e;
            n_pt_wr++;
            check("pt_write_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pt_write", {16'd0, pt_addr, pt_wrdata}, {16'd0, e.a, e.d});
            end
        end
    end

    // Software RC4 (optionally drop-N) on m_s for the message in ct_mem.
    task automatic model_run();
        int         mi = 0;
        int         mj = 0;
        int         n;
        logic [7:0] t;
        n = int'(ct_mem[0]);
        exp_pt[0] = ct_mem[0];
        exp_q.push_back({8'd0, ct_mem[0]});
        if (n > 0) begin
            for (int d = 0; d < DROP; d++) begin
                mi = (mi + 1) % 256;
                mj = (mj + int'(m_s[mi])) % 256;
                t = m_s[mi]; m_s[mi] = m_s[mj]; m_s[mj] = t;
            end
            for (int k = 1; k <= n; k++) begin
                mi = (mi + 1) % 256;
                mj = (mj + int'(m_s[mi])) % 256;
                t = m_s[mi]; m_s[mi] = m_s[mj]; m_s[mj] = t;
                t = m_s[(int'(m_s[mi]) + int'(m_s[mj])) % 256];
                exp_pt[k] = ct_mem[k] ^ t;
                exp_q.push_back({8'(k), exp_pt[k]});
            end
        end
    endtask

    function automatic int lat(input int l);
        return (l == 0) ? 2 : 2 + 4 * DROP + 6 * l;
    endfunction

    function automatic int pt_diffs(input int l);
        int d = 0;
        for (int k = 0; k <= l; k++) if (pt_mem[k] !== exp_pt[k]) d++;
        return d;
    endfunction

    function automatic int s_diffs();
        int d = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== m_s[a]) d++;
        return d;
    endfunction

    task automatic load_identity();
        load_ident = 1'b1;
        @(posedge clk); #1;
        load_ident = 1'b0;
        for (int a = 0; a < 256; a++) m_s[a] = s_mem[a];
    endtask

    task automatic start_pulse();
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic busy_cycles(output int n);
        n = 0;
        while (rdy !== 1'b1 && n < 20000) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int n, m, idle, snap_pt, snap_s;

        for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", {31'd0, rdy}, 32'd1);
        check("rst_s_wren", {31'd0, s_wren}, 32'd0);
        check("rst_pt_wren", {31'd0, pt_wren}, 32'd0);
        check("rst_s_addr", {24'd0, s_addr}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_rdy", {31'd0, rdy}, 32'd1);

        // Empty message: only pt[0] written, no S activity
        load_identity();
        ct_mem[0] = 8'h00;
        model_run();
        snap_s = n_s_wr;
        start_pulse();
        busy_cycles(n);
        check("l0_latency", n, lat(0));
        check("l0_queue", exp_q.size(), 0);
        check("l0_no_s_wr", n_s_wr - snap_s, 0);
        check("l0_pt0", {24'd0, pt_mem[0]}, 32'h00);

        // One byte, i=j=1 swap no-op
        load_identity();
        ct_mem[0] = 8'h01; ct_mem[1] = 8'h00;
        model_run();
        start_pulse();
        busy_cycles(n);
        check("l1_latency", n, lat(1));
        check("l1_queue", exp_q.size(), 0);
        check("l1_pt_model", pt_diffs(1), 0);
`ifndef PRGA_DROP256_EN
        check("l1_pt1", {24'd0, pt_mem[1]}, 32'h02);
`endif
        check("l1_s_final", s_diffs(), 0);

        // Two bytes with a real swap
        load_identity();
        ct_mem[0] = 8'h02; ct_mem[1] = 8'hFF; ct_mem[2] = 8'h00;
        model_run();
        start_pulse();
        busy_cycles(n);
        check("l2_latency", n, lat(2));
        check("l2_queue", exp_q.size(), 0);
        check("l2_pt_model", pt_diffs(2), 0);
        check("l2_s_final", s_diffs(), 0);
`ifndef PRGA_DROP256_EN
        check("l2_pt", {8'd0, pt_mem[0], pt_mem[1], pt_mem[2]}, 32'h0002FD05);
        check("l2_s23", {16'd0, s_mem[2], s_mem[3]}, 32'h0302);
`endif

        // Reset during the second WRP, then a clean rerun
        load_identity();
        ct_mem[0] = 8'h05;
        for (int k = 1; k <= 5; k++) ct_mem[k] = 8'($urandom_range(0, 255));
        model_run();
        snap_pt = n_pt_wr;
        start_pulse();
        n = 0;
        while (!(pt_wren === 1'b1 && pt_addr === 8'd2) && n < 20000) begin
            n++;
            @(posedge clk); #1;
        end
        check("rst_mid_reach", {23'd0, pt_wren, pt_addr}, {23'd0, 1'b1, 8'd2});
        check("rst_mid_writes_before", n_pt_wr - snap_pt, 2);
        snap_pt = n_pt_wr;
        snap_s  = n_s_wr;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid_rdy", {31'd0, rdy}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_no_pt_wr", n_pt_wr - snap_pt, 0);
        check("rst_mid_no_s_wr", n_s_wr - snap_s, 0);
        check("rst_mid_left", exp_q.size(), 4);
        exp_q.delete();
        load_identity();
        model_run();
        start_pulse();
        busy_cycles(n);
        check("rerun_latency", n, lat(5));
        check("rerun_queue", exp_q.size(), 0);
        check("rerun_pt", pt_diffs(5), 0);
        check("rerun_s", s_diffs(), 0);

        // en pulse while busy must be ignored
        load_identity();
        ct_mem[0] = 8'h01; ct_mem[1] = 8'h5A;
        model_run();
        snap_pt = n_pt_wr;
        start_pulse();
        n = 0;
        repeat (3) begin
            @(posedge clk); #1;
            n++;
        end
        en = 1'b1;
        @(posedge clk); #1;
        n++;
        en = 1'b0;
        busy_cycles(m);
        check("busy_en_latency", n + m, lat(1));
        repeat (3) @(posedge clk);
        #1;
        check("busy_en_no_restart", {31'd0, rdy}, 32'd1);
        check("busy_en_writes", n_pt_wr - snap_pt, 2);
        check("busy_en_queue", exp_q.size(), 0);

        // en held high: back-to-back runs with one idle cycle between
        for (int a = 0; a < 256; a++) m_s[a] = s_mem[a];
        model_run();
        model_run();
        en = 1'b1;
        @(posedge clk); #1;
        busy_cycles(n);
        idle = 0;
        while (rdy === 1'b1 && idle < 100) begin
            idle++;
            @(posedge clk); #1;
        end
        en = 1'b0;
        busy_cycles(m);
        check("b2b_first", n, lat(1));
        check("b2b_idle", idle, 1);
        check("b2b_second", m, lat(1));
        check("b2b_queue", exp_q.size(), 0);
        check("b2b_s", s_diffs(), 0);

        // Longest message
        load_identity();
        ct_mem[0] = 8'hFF;
        for (int k = 1; k <= 255; k++) ct_mem[k] = 8'($urandom_range(0, 255));
        model_run();
        start_pulse();
        busy_cycles(n);
        check("l255_latency", n, lat(255));
        check("l255_queue", exp_q.size(), 0);
        check("l255_pt", pt_diffs(255), 0);
        check("l255_s", s_diffs(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prga.md
PRGA -- requirements
Module: prga

Interface
REQ-001 The block SHALL have no parameters; reset rst_n, synchronous, active-low; clock clk.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 en  input  1  start request, sampled only while rdy=1.
REQ-005 rdy  output  1  high when idle and able to accept en.
REQ-006 s_addr / s_rddata / s_wrdata / s_wren  output 8 / input 8 / output 8 / output 1  port to 256x8 S RAM, already permuted by the key-scheduling block.
REQ-007 ct_addr / ct_rddata  output 8 / input 8  ciphertext RAM read port; ct[0] is message length L.
REQ-008 pt_addr / pt_wrdata / pt_wren  output 8 / output 8 / output 1  plaintext RAM write port.
REQ-009 All RAM reads SHALL assume 1-cycle latency: address in cycle N, data valid in cycle N+1.

Function
REQ-010 States SHALL be IDLE, LEN, WLEN, RDI, RDJ, WRI, WRJ, RDP, WRP.
REQ-011 IDLE: rdy=1, all wren=0; en=1 -> LEN; i, j cleared to 0.
REQ-012 LEN: ct_addr=0 -> WLEN.
REQ-013 WLEN: ml<=ct_rddata; pt_addr=0, pt_wrdata=ct_rddata, pt_wren=1; k<=1; ml=0 -> IDLE, else -> RDI.
REQ-014 RDI: s_addr=i+1 (mod 256); i<=i+1 -> RDJ.
REQ-015 RDJ: si<=s_rddata; j<=j+s_rddata (mod 256); s_addr=j+s_rddata -> WRI.
REQ-016 WRI: sj<=s_rddata; s_addr=i, s_wrdata=s_rddata, s_wren=1 -> WRJ.
REQ-017 WRJ: s_addr=j, s_wrdata=si, s_wren=1 -> RDP.
REQ-018 RDP: s_addr=si+sj (mod 256); ct_addr=k -> WRP.
REQ-019 WRP: pt_addr=k, pt_wrdata=s_rddata XOR ct_rddata, pt_wren=1; k=ml -> IDLE, else k<=k+1 -> RDI.
REQ-020 All address arithmetic SHALL be 8-bit, wrapping modulo 256; k and ml 8-bit, so L max 255.
REQ-021 i=j SHALL leave S[i] unchanged (WRI then WRJ both write si).
REQ-022 Latency from en accepted: 2+6L cycles with rdy=0; rdy=1 in the following cycle.
REQ-023 en SHALL be ignored while rdy=0; en held high in IDLE starts a new run immediately.
REQ-024 At most one of s_wren, pt_wren SHALL be high in any cycle; address outputs SHALL be 0 when not used.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE regardless of state; next cycle rdy=1, s_wren=0, pt_wren=0.
REQ-026 Reset mid-message SHALL abandon the run with no further RAM writes; S and pt contents are then undefined.
REQ-027 i, j, k, ml, si, sj SHALL reset to 0.

Configuration
REQ-028 Macro PRGA_DROP256_EN defined: after WLEN with ml>0, 256 swap-only iterations (RDI, RDJ, WRI, WRJ; no RDP/WRP, no pt writes) SHALL run before byte 1, i and j carried on; latency becomes 2+1024+6L.
REQ-029 PRGA_DROP256_EN undefined: no drop phase, no 9-bit drop counter in the netlist.

Structure
REQ-030 State enum and constants (MSG_LEN_MAX=255, DROP_N=256) SHALL live in package rc4_pkg, shared with the key-scheduling block.
REQ-031 The block SHALL be a single module with no sub-module; one registered state process plus one combinational output decode.

Verification
REQ-032 S identity, ct={0x00}, pulse en -> pt[0]=0x00 written, rdy=0 for 2 cycles, no s_wren.
REQ-033 S identity, ct={0x01,0x00} -> i=j=1 swap no-op, pt={0x01,0x02}, rdy=0 for 8 cycles.
REQ-034 S identity, ct={0x02,0xFF,0x00} -> pt={0x02,0xFD,0x05}; S[2]=0x03, S[3]=0x02 afterwards.
REQ-035 L=5 run, rst_n low for one cycle during second WRP -> no writes afterwards, rdy=1 next cycle; rerun with S reloaded matches the fresh-run result.
REQ-036 en pulses during busy ignored; en held high gives back-to-back runs with exactly one IDLE cycle between.
REQ-037 PRGA_DROP256_EN, S identity, ct={0x01,0x00} -> pt[1] matches software RC4-drop256 model; rdy=0 for 1032 cycles.
